// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage of the five-stage MIPS pipeline. Single-cycle
//               logic/shift/arith ops are combinational; DIV/DIVU use an
//               iterative radix-2 restoring divider that stalls the pipeline.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               aluop_i, alusel_i - operation code and result class
//               reg1_i, reg2_i    - operands (dividend/divisor; shamt/value)
//               wd_i, wreg_i      - destination address / write enable
//               wd_o, wreg_o,
//               wdata_o           - GPR write-back triple
//               whilo_o, hi_o,
//               lo_o              - HI/LO write (remainder / quotient)
//               stallreq_o        - hold request for IF/ID/EX
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] c_OP_AND  = 8'b00100100;
  localparam logic [7:0] c_OP_OR   = 8'b00100101;
  localparam logic [7:0] c_OP_XOR  = 8'b00100110;
  localparam logic [7:0] c_OP_NOR  = 8'b00100111;
  localparam logic [7:0] c_OP_SLL  = 8'b01111100;
  localparam logic [7:0] c_OP_SRL  = 8'b00000010;
  localparam logic [7:0] c_OP_SRA  = 8'b00000011;
  localparam logic [7:0] c_OP_ADDU = 8'b00100001;
  localparam logic [7:0] c_OP_SUBU = 8'b00100011;
  localparam logic [7:0] c_OP_SLT  = 8'b00101010;
  localparam logic [7:0] c_OP_SLTU = 8'b00101011;
  localparam logic [7:0] c_OP_DIV  = 8'b00011010;
  localparam logic [7:0] c_OP_DIVU = 8'b00011011;

  localparam logic [2:0] c_SEL_LOGIC = 3'b001;
  localparam logic [2:0] c_SEL_SHIFT = 3'b010;
  localparam logic [2:0] c_SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // --------------------------------------------------------------------------
  // Single-cycle datapath
  // --------------------------------------------------------------------------
  logic [31:0] w_logic;
  logic [31:0] w_shift;
  logic [31:0] w_arith;
  logic [31:0] w_result;

  always_comb begin
    w_logic = 32'd0;
    case (aluop_i)
      c_OP_AND: w_logic = reg1_i & reg2_i;
      c_OP_OR:  w_logic = reg1_i | reg2_i;
      c_OP_XOR: w_logic = reg1_i ^ reg2_i;
      c_OP_NOR: w_logic = ~(reg1_i | reg2_i);
      default:  w_logic = 32'd0;
    endcase
  end

  always_comb begin
    w_shift = 32'd0;
    case (aluop_i)
      c_OP_SLL: w_shift = reg2_i << reg1_i[4:0];
      c_OP_SRL: w_shift = reg2_i >> reg1_i[4:0];
      c_OP_SRA: w_shift = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:  w_shift = 32'd0;
    endcase
  end

  always_comb begin
    w_arith = 32'd0;
    case (aluop_i)
      c_OP_ADDU: w_arith = reg1_i + reg2_i;
      c_OP_SUBU: w_arith = reg1_i + ~reg2_i + 32'd1;
      c_OP_SLT:  w_arith = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      c_OP_SLTU: w_arith = {31'd0, reg1_i < reg2_i};
      default:   w_arith = 32'd0;
    endcase
  end

  always_comb begin
    w_result = 32'd0;
    case (alusel_i)
      c_SEL_LOGIC: w_result = w_logic;
      c_SEL_SHIFT: w_result = w_shift;
      c_SEL_ARITH: w_result = w_arith;
      default:     w_result = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Iterative divider
  // --------------------------------------------------------------------------
  div_state_t  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;   // partial remainder
  logic [31:0] r_quo;   // starts as |dividend|, quotient bits shift in at LSB
  logic [31:0] r_dvs;   // |divisor|
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;

  assign w_is_div = (aluop_i == c_OP_DIV) || (aluop_i == c_OP_DIVU);
  assign w_a_neg  = (aluop_i == c_OP_DIV) && reg1_i[31];
  assign w_b_neg  = (aluop_i == c_OP_DIV) && reg2_i[31];

  // The remainder is always below the divisor, so after the shift the trial
  // value fits in 33 bits and the kept result fits back in 32.
  assign w_trial   = {r_rem, r_quo[31]};
  assign w_diff    = w_trial - {1'b0, r_dvs};
  assign w_rem_nxt = w_diff[32] ? w_trial[31:0] : w_diff[31:0];
  assign w_quo_nxt = {r_quo[30:0], ~w_diff[32]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            if (reg2_i == 32'd0) begin
              r_hi    <= 32'd0;
              r_lo    <= 32'd0;
              r_state <= S_DONE;
            end else begin
              r_quo   <= w_a_neg ? (32'd0 - reg1_i) : reg1_i;
              r_dvs   <= w_b_neg ? (32'd0 - reg2_i) : reg2_i;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_rem   <= 32'd0;
              r_cnt   <= 5'd0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            // Sign fix-up is folded into the last iteration so the result
            // is already registered when DONE presents it.
            r_lo    <= r_neg_q ? (32'd0 - w_quo_nxt) : w_quo_nxt;
            r_hi    <= r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // The pipeline advances at the end of this cycle, so the finished
          // divide is gone from the inputs by the time IDLE looks at them.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all forced to zero while reset is held)
  // --------------------------------------------------------------------------
  assign wd_o       = rst ? 5'd0  : wd_i;
  assign wreg_o     = rst ? 1'b0  : wreg_i;
  assign wdata_o    = rst ? 32'd0 : w_result;
  assign whilo_o    = !rst && (r_state == S_DONE);
  assign hi_o       = rst ? 32'd0 : r_hi;
  assign lo_o       = rst ? 32'd0 : r_lo;
  assign stallreq_o = !rst && (((r_state == S_IDLE) && w_is_div) ||
                               (r_state == S_BUSY));

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: vector table, randomized
//               single-cycle ops and divides against a behavioural model,
//               and hand-written divider / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  localparam logic [7:0] c_NOP  = 8'b00000000;
  localparam logic [7:0] c_AND  = 8'b00100100;
  localparam logic [7:0] c_OR   = 8'b00100101;
  localparam logic [7:0] c_XOR  = 8'b00100110;
  localparam logic [7:0] c_NOR  = 8'b00100111;
  localparam logic [7:0] c_SLL  = 8'b01111100;
  localparam logic [7:0] c_SRL  = 8'b00000010;
  localparam logic [7:0] c_SRA  = 8'b00000011;
  localparam logic [7:0] c_ADDU = 8'b00100001;
  localparam logic [7:0] c_SUBU = 8'b00100011;
  localparam logic [7:0] c_SLT  = 8'b00101010;
  localparam logic [7:0] c_SLTU = 8'b00101011;
  localparam logic [7:0] c_DIV  = 8'b00011010;
  localparam logic [7:0] c_DIVU = 8'b00011011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: each opcode names its result class and its arithmetic value;
  // the output is that value only if the selector names the same class.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [2:0]  cls;
    logic [31:0] r;
    logic [4:0]  sh;
    longint      sa;
    longint      sb;
    sh = a[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      c_AND:  begin cls = 3'b001; r = a & b; end
      c_OR:   begin cls = 3'b001; r = a | b; end
      c_XOR:  begin cls = 3'b001; r = a ^ b; end
      c_NOR:  begin cls = 3'b001; r = ~(a | b); end
      c_SLL:  begin cls = 3'b010; r = 32'(longint'(b) * (longint'(1) << sh)); end
      c_SRL:  begin cls = 3'b010; r = 32'(longint'(b) / (longint'(1) << sh)); end
      c_SRA:  begin cls = 3'b010; r = 32'(sb >>> sh); end
      c_ADDU: begin cls = 3'b100; r = 32'(longint'(a) + longint'(b)); end
      c_SUBU: begin cls = 3'b100; r = 32'(longint'(a) - longint'(b)); end
      c_SLT:  begin cls = 3'b100; r = (sa < sb) ? 32'd1 : 32'd0; end
      c_SLTU: begin cls = 3'b100; r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0; end
      default: begin cls = 3'b000; r = 32'd0; end
    endcase
    return (cls != 3'b000 && sel == cls) ? r : 32'd0;
  endfunction

  function automatic void ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      if (op == c_DIV) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  task automatic set_nop();
    aluop = c_NOP; alusel = 3'b000; reg1 = 32'd0; reg2 = 32'd0; wd = 5'd0; wreg = 1'b0;
  endtask

  // Entered just after a rising edge; holds the divide on the inputs (as the
  // stalled ID/EX register would) until whilo, then lets the pipeline advance.
  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_stalls);
    int stalls;
    int c;
    bit seen;
    bit gap;
    stalls = 0; c = 0; seen = 1'b0; gap = 1'b0;
    aluop = op; alusel = 3'b000; reg1 = a; reg2 = b; wd = 5'd3; wreg = 1'b0;
    while (!seen && !gap && c < 100) begin
      @(negedge clk);
      c++;
      if (whilo_o) begin
        seen = 1'b1;
        check({name, " stall_in_done"}, {31'd0, stallreq_o}, 32'd0);
        check({name, " lo"}, lo_o, exp_lo);
        check({name, " hi"}, hi_o, exp_hi);
      end else if (stallreq_o) begin
        stalls++;
      end else begin
        gap = 1'b1;
      end
    end
    check({name, " done_seen"}, {31'd0, seen}, 32'd1);
    check({name, " stall_cycles"}, stalls, exp_stalls);
    @(posedge clk);
    #1;
    set_nop();
  endtask

  vec_t tbl[13];
  logic [7:0] ops[11];

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic [2:0]  sel;
    bit          bad;

    ops = '{c_AND, c_OR, c_XOR, c_NOR, c_SLL, c_SRL, c_SRA, c_ADDU, c_SUBU, c_SLT, c_SLTU};

    tbl[0]  = '{c_OR,   3'b001, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0};
    tbl[1]  = '{c_SRA,  3'b010, 32'd4,        32'h80000000, 32'hF8000000};
    tbl[2]  = '{c_SLL,  3'b010, 32'd31,       32'd1,        32'h80000000};
    tbl[3]  = '{c_SUBU, 3'b100, 32'd0,        32'd1,        32'hFFFFFFFF};
    tbl[4]  = '{c_SLT,  3'b100, 32'hFFFFFFFF, 32'd1,        32'd1};
    tbl[5]  = '{c_SLTU, 3'b100, 32'hFFFFFFFF, 32'd1,        32'd0};
    tbl[6]  = '{c_ADDU, 3'b100, 32'hFFFFFFFF, 32'd1,        32'd0};
    tbl[7]  = '{c_SRL,  3'b010, 32'd8,        32'h80000000, 32'h00800000};
    tbl[8]  = '{c_NOR,  3'b001, 32'd0,        32'hF0F0F0F0, 32'h0F0F0F0F};
    tbl[9]  = '{c_AND,  3'b010, 32'hFF,       32'hFF,       32'd0};
    tbl[10] = '{c_ADDU, 3'b011, 32'd5,        32'd6,        32'd0};
    tbl[11] = '{c_XOR,  3'b001, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00};
    tbl[12] = '{c_SLT,  3'b100, 32'd1,        32'hFFFFFFFF, 32'd0};

    // Reset state, with a divide and a live write sitting on the inputs.
    rst = 1'b1;
    aluop = c_DIV; alusel = 3'b100; reg1 = 32'd5; reg2 = 32'd1; wd = 5'd7; wreg = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst stallreq", {31'd0, stallreq_o}, 32'd0);
    check("rst whilo",    {31'd0, whilo_o},    32'd0);
    check("rst wdata",    wdata_o,             32'd0);
    check("rst wd",       {27'd0, wd_o},       32'd0);
    check("rst wreg",     {31'd0, wreg_o},     32'd0);
    check("rst hi",       hi_o,                32'd0);
    check("rst lo",       lo_o,                32'd0);
    set_nop();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      aluop = tbl[i].op; alusel = tbl[i].sel; reg1 = tbl[i].a; reg2 = tbl[i].b;
      wd = 5'(i + 1); wreg = i[0];
      #1;
      check($sformatf("vec%0d wdata", i), wdata_o, tbl[i].exp);
      check($sformatf("vec%0d wd", i), {27'd0, wd_o}, 32'(i + 1));
      check($sformatf("vec%0d wreg", i), {31'd0, wreg_o}, {31'd0, i[0]});
      #4;
    end

    // Randomized single-cycle ops.
    for (int i = 0; i < 300; i++) begin
      op  = ops[$urandom_range(0, 10)];
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (op == c_SLL || op == c_SRL || op == c_SRA) sel = 3'b010;
        else if (op == c_ADDU || op == c_SUBU || op == c_SLT || op == c_SLTU) sel = 3'b100;
        else sel = 3'b001;
      end
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40));
      aluop = op; alusel = sel; reg1 = a; reg2 = b;
      wd = 5'($urandom); wreg = 1'($urandom);
      #1;
      check($sformatf("rnd%0d op=%02h sel=%0d a=%08h b=%08h", i, op, sel, a, b),
            wdata_o, ref_alu(op, sel, a, b));
      check($sformatf("rnd%0d wd", i), {27'd0, wd_o}, {27'd0, wd});
      #4;
    end
    set_nop();
    @(posedge clk);
    #1;

    // Directed divides.
    run_div("div -7/2", c_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_div("divu ffffffff/16", c_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 32'h0000000F, 33);
    run_div("divu 100/7 b2b", c_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    @(negedge clk);
    check("hold lo after divide", lo_o, 32'd14);
    check("hold hi after divide", hi_o, 32'd2);
    check("no whilo after done", {31'd0, whilo_o}, 32'd0);
    @(posedge clk);
    #1;
    run_div("div by 0", c_DIV, 32'd12345, 32'd0, 32'd0, 32'd0, 1);
    run_div("div intmin/-1", c_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
    run_div("div 7/-2", c_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);

    // Reset in the middle of a divide.
    aluop = c_DIV; alusel = 3'b000; reg1 = 32'd1000; reg2 = 32'd3; wd = 5'd0; wreg = 1'b0;
    bad = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (!stallreq_o || whilo_o) bad = 1'b1;
    end
    check("pre-reset stall through BUSY 10", {31'd0, bad}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_nop();
    @(negedge clk);
    check("post-reset stall", {31'd0, stallreq_o}, 32'd0);
    check("post-reset whilo", {31'd0, whilo_o}, 32'd0);
    check("post-reset hi", hi_o, 32'd0);
    check("post-reset lo", lo_o, 32'd0);
    check("post-reset wdata", wdata_o, 32'd0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (whilo_o || stallreq_o) bad = 1'b1;
    end
    check("abandoned divide silent", {31'd0, bad}, 32'd0);
    @(posedge clk);
    #1;
    run_div("div 9/3 after reset", c_DIV, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Randomized divides against the model.
    for (int i = 0; i < 10; i++) begin
      op = ($urandom_range(0, 1) == 0) ? c_DIV : c_DIVU;
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'd0 - 32'($urandom_range(1, 20));
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      ref_div(op, a, b, q, r);
      run_div($sformatf("rnddiv%0d op=%02h %08h/%08h", i, op, a, b), op, a, b, q, r,
              (b == 32'd0) ? 1 : 33);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its `ex_*` outputs. It produces the register write-back triple for the EX/MEM register, plus a HI/LO write for division. Single-cycle ops are combinational; DIV/DIVU run on an iterative radix-2 divider that stalls the pipeline.

## Interface
- No parameters. Data width is fixed at 32, register address at 5, aluop at 8, alusel at 3.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `aluop_i` in 8: operation code from the ID/EX register.
- `alusel_i` in 3: result class. 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH.
- `reg1_i` in 32: operand 1. Dividend; for shifts, the shift amount (bits [4:0]).
- `reg2_i` in 32: operand 2. Divisor; for shifts, the value shifted.
- `wd_i` in 5: destination register address.
- `wreg_i` in 1: destination write enable.
- `wd_o` out 5: equals `wd_i`.
- `wreg_o` out 1: equals `wreg_i`.
- `wdata_o` out 32: result for GPR write-back.
- `whilo_o` out 1: HI/LO write strobe. High for exactly one cycle per completed divide.
- `hi_o` out 32: remainder.
- `lo_o` out 32: quotient.
- `stallreq_o` out 1: requests that IF/ID/EX hold. The ID/EX register keeps its outputs stable while this is high.

## Operation
- Opcodes:
  - NOP 00000000
  - AND 00100100, OR 00100101, XOR 00100110, NOR 00100111
  - SLL 01111100, SRL 00000010, SRA 00000011
  - ADDU 00100001, SUBU 00100011
  - SLT 00101010, SLTU 00101011
  - DIV 00011010, DIVU 00011011
- Logic ops: bitwise on reg1/reg2.
- Shifts: `reg2` shifted by `reg1[4:0]`. SRA fills with `reg2[31]`.
- ADDU/SUBU: modulo 2^32, with no overflow trap.
  - SUBU = reg1 + ~reg2 + 1.
- SLT: signed compare, result 0 or 1. SLTU: unsigned compare, result 0 or 1.
- `wdata_o` mux by `alusel_i`:
  - LOGIC: logic result.
  - SHIFT: shift result.
  - ARITH: add/sub/slt result.
  - Any other value: 0.
- Unknown aluop within a class yields 0.
- DIV/DIVU do not write a GPR. The decoder already drives `wreg_i`=0 for them; this block passes it through unchanged.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE, op DIV/DIVU, divisor ≠ 0:
    - Latch |dividend|, |divisor|, both signs, and the signed flag. DIVU treats operands as unsigned.
    - Clear the partial remainder.
    - Set counter=0. Go to BUSY.
  - IDLE, op DIV/DIVU, divisor = 0: go to DONE with quotient=0, remainder=0.
  - BUSY, each cycle:
    - Shift {rem, quo} left 1.
    - Trial-subtract the divisor from the 33-bit remainder. If non-negative, keep the difference and set the quotient LSB.
    - Increment counter. After the 32nd iteration go to DONE.
  - DONE:
    - Apply signed fix-up. The quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
    - Present `hi_o`/`lo_o` with `whilo_o`=1.
    - Unconditionally go to IDLE next edge.
- `stallreq_o` = (IDLE and op is DIV/DIVU) or BUSY. It is 0 in DONE.
- `hi_o`/`lo_o` hold their last value when `whilo_o`=0. The consumer ignores them then.

## Timing
- Non-divide ops: zero latency, combinational from inputs to `wdata_o`/`wd_o`/`wreg_o`.
- Divide, nonzero divisor:
  - Cycle 0: IDLE, stall.
  - Cycles 1–32: BUSY, stall.
  - Cycle 33: DONE, `whilo_o`=1, no stall.
  - Total: 33 stall cycles. The result is visible in cycle 33 and the pipeline advances at the end of cycle 33.
- Divide by zero: cycle 0 IDLE with stall; cycle 1 DONE with hi=lo=0. One stall cycle.
- Back-to-back divides: the second divide appears in IDLE after DONE and starts normally. The FSM never re-triggers on the instruction that just completed, because DONE→IDLE coincides with the pipeline advancing.
- Reset while `rst`=1:
  - FSM forced to IDLE, counter 0, `hi_o`=`lo_o`=0.
  - `whilo_o`=0, `stallreq_o`=0.
  - `wdata_o`=0, `wd_o`=0, `wreg_o`=0.
- Reset mid-divide: the divide is abandoned. `whilo_o` is never asserted for it.
- INT_MIN / −1 (signed): the quotient wraps to 0x80000000 and the remainder is 0. No trap.

## Test plan
- Logic and shift:
  - OR 0x0F0F0000,0x0000F0F0 → 0x0F0FF0F0.
  - SRA reg1=4, reg2=0x80000000 → 0xF8000000.
  - SLL reg1=31, reg2=1 → 0x80000000.
- Arith:
  - SUBU 0,1 → 0xFFFFFFFF.
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU same operands → 0.
  - ADDU 0xFFFFFFFF,1 → 0.
- DIV −7/2:
  - `stallreq_o` high exactly 33 cycles.
  - Then one cycle with `whilo_o`=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0xFFFFFFFF/16 → lo=0x0FFFFFFF, hi=0xF. Follow immediately with a second DIVU 100/7 → lo=14, hi=2, with 33 stall cycles again.
- DIV by 0 → one stall cycle, then `whilo_o`=1 with hi=lo=0.
- Assert `rst` at BUSY cycle 10 → next cycle IDLE, stall=0, all outputs 0. No `whilo_o` for that divide; a fresh DIV 9/3 afterwards gives lo=3, hi=0.
